// File: rtl/wb_csr_bank_if.sv
// wb_csr_bank_if: Wishbone classic bus bundle shared by the CSR bank and its master.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADDR_WIDTH-1:0]     adr;
  logic [DATA_WIDTH-1:0]     wdat;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic                      ack;
  logic                      err;
  logic [DATA_WIDTH-1:0]     rdat;
  modport slave (input cyc, stb, we, adr, wdat, sel, output ack, err, rdat);
  modport master (output cyc, stb, we, adr, wdat, sel, input ack, err, rdat);
endinterface

// File: rtl/wb_csr_bank.sv
// wb_csr_bank: Wishbone slave exposing read/write control registers and read-only status registers.
module wb_csr_bank #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    CTRL_NUM    = 8,
  parameter int                    STAT_NUM    = 4,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  wb_if.slave                            s_wb,
  output logic [CTRL_NUM*DATA_WIDTH-1:0] ctrl_o,
  output logic [CTRL_NUM-1:0]            wr_stb_o,
  input  logic [STAT_NUM*DATA_WIDTH-1:0] stat_i
);
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                         state_q;
  logic [3:0]                     cnt_q;
  logic                           we_q, ack_q, err_q;
  logic [ADDR_WIDTH-1:0]          adr_q, adr_c, offset, idx;
  logic [DATA_WIDTH-1:0]          wdat_q, wdat_c, rdat_q, rdat_d;
  logic [SW-1:0]                  sel_q, sel_c;
  logic                           we_c, is_ctrl, is_stat, bad, respond;
  logic [CTRL_NUM*DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [CTRL_NUM-1:0]            wr_stb_d, wr_stb_q;
  // IDLE decodes the live bus so a zero-wait slave can answer on the request edge
  assign adr_c   = (state_q == IDLE) ? s_wb.adr : adr_q;
  assign wdat_c  = (state_q == IDLE) ? s_wb.wdat : wdat_q;
  assign sel_c   = (state_q == IDLE) ? s_wb.sel : sel_q;
  assign we_c    = (state_q == IDLE) ? s_wb.we : we_q;
  assign offset  = adr_c - BASE_ADDR;
  assign idx     = offset >> 2;
  assign is_ctrl = idx < ADDR_WIDTH'(CTRL_NUM);
  assign is_stat = !is_ctrl && idx < ADDR_WIDTH'(CTRL_NUM + STAT_NUM);
  assign bad     = adr_c < BASE_ADDR || offset[1:0] != 2'b00 || !(is_ctrl || is_stat) || (we_c && is_stat);
  assign respond = s_wb.cyc && ((state_q == IDLE) ? s_wb.stb && WAIT_STATES == 0
                                                  : state_q == WAIT && cnt_q == 4'd0);
  always_comb begin
    ctrl_d   = ctrl_q;
    wr_stb_d = '0;
    rdat_d   = rdat_q;
    for (int r = 0; r < CTRL_NUM; r++) begin
      if (idx == ADDR_WIDTH'(r)) begin
        if (we_c) begin
          wr_stb_d[r] = 1'b1;
          for (int b = 0; b < SW; b++)
            if (sel_c[b]) ctrl_d[r*DATA_WIDTH+b*8 +: 8] = wdat_c[b*8 +: 8];
        end else begin
          rdat_d = ctrl_q[r*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    for (int s = 0; s < STAT_NUM; s++)
      if (idx == ADDR_WIDTH'(CTRL_NUM + s)) rdat_d = stat_i[s*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdat_q   <= '0;
      ctrl_q   <= '0;
      wr_stb_q <= '0;
    end else begin
      ack_q    <= respond && !bad;
      err_q    <= respond && bad;
      wr_stb_q <= (respond && !bad) ? wr_stb_d : '0;
      if (respond && !bad) begin
        ctrl_q <= ctrl_d;
        rdat_q <= rdat_d;
      end
      case (state_q)
        IDLE: if (s_wb.cyc && s_wb.stb) begin
          adr_q   <= s_wb.adr;
          wdat_q  <= s_wb.wdat;
          sel_q   <= s_wb.sel;
          we_q    <= s_wb.we;
          cnt_q   <= 4'(WAIT_STATES - 1);
          state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          state_q <= !s_wb.cyc ? IDLE : (cnt_q == 4'd0) ? RESP : WAIT;
          cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign s_wb.ack  = ack_q;
  assign s_wb.err  = err_q;
  assign s_wb.rdat = rdat_q;
  assign ctrl_o    = ctrl_q;
  assign wr_stb_o  = wr_stb_q;
endmodule
